layer_compositor: RTL and testbench

Parametrised, pipelined successor to the two-level video mux. Builds one background pixel from the camera path: raw, selected channel grey, threshold mask, or Y channel with a mask colour. Overlays `NUM_LAYERS` sprite and crosshair layers on top by fixed priority with colour-key transparency and per-layer blink. Configuration is shadowed and applied only at frame boundaries. Sits between the camera/threshold/sprite pipeline and the TMDS/HDMI output stage on the pixel clock.

---
 rtl/video_pkg.sv | 21 ++
 rtl/layer_priority_select.sv | 35 +++
 rtl/layer_compositor.sv | 215 +++++++++++++++++++++
 tb/tb_layer_compositor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared types and constants for the pixel-clock video path.
//   pixel_t            : 8:8:8 RGB pixel.
//   bg_mode_e          : background source selection for the compositor.
//   DEFAULT_TEST_COLOR : colour emitted while the test override is active.
// ---------------------------------------------------------------------------
package video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    BG_CAMERA  = 2'd0,
    BG_CHANNEL = 2'd1,
    BG_THRESH  = 2'd2,
    BG_YMASK   = 2'd3
  } bg_mode_e;

  localparam pixel_t DEFAULT_TEST_COLOR = 24'hFF7700;

endpackage

// File: rtl/layer_priority_select.sv
// ---------------------------------------------------------------------------
// layer_priority_select
// Combinational fixed-priority picker: the highest-index set bit of the
// visibility mask wins.
//   vis_in   : per-layer visibility mask.
//   idx_out  : winning layer index, NUM_LAYERS when nothing is visible.
//   valid_out: at least one layer is visible.
// ---------------------------------------------------------------------------
module layer_priority_select
  import video_pkg::*;
#(
  parameter int NUM_LAYERS = 4
) (
  input  logic [NUM_LAYERS-1:0]         vis_in,
  output logic [$clog2(NUM_LAYERS):0]   idx_out,
  output logic                          valid_out
);

  localparam int TOP_W = $clog2(NUM_LAYERS) + 1;

  // Scan from the highest-priority layer down; first visible layer is kept.
  always_comb begin
    idx_out   = TOP_W'(NUM_LAYERS);
    valid_out = 1'b0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (vis_in[k] && !valid_out) begin
        idx_out   = TOP_W'(k);
        valid_out = 1'b1;
      end else begin
        // a higher-priority layer already won, or this one is hidden
      end
    end
  end

endmodule

// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
// Two-stage pixel compositor: builds a background pixel from the camera path
// and overlays NUM_LAYERS colour-keyed, blinkable layers by fixed priority.
// Configuration is shadowed and taken only on new_frame_in.
//   clk_pixel_in / rst_n_in      : pixel clock, synchronous active-low reset.
//   new_frame_in                 : frame-start pulse, loads shadow config.
//   active/hsync/vsync_in        : timing aligned with the pixel inputs.
//   bg_mode/layer_enable/layer_blink/key_color/mask_color_in : shadowed config.
//   test_force_in                : live override to TEST_COLOR.
//   camera_pixel/camera_y/selected_channel/thresholded_in : background sources.
//   layer_pixels_in              : layer k at [k*PIXEL_W +: PIXEL_W].
//   pixel_out, active/hsync/vsync_out, top_layer_out : 2-cycle-delayed result.
// ---------------------------------------------------------------------------
module layer_compositor
  import video_pkg::*;
#(
  parameter int                 NUM_LAYERS  = 4,
  parameter int                 PIXEL_W     = 24,
  parameter int                 CHAN_W      = 8,
  parameter int                 FRAME_CNT_W = 6,
  parameter int                 BLINK_BIT   = 4,
  parameter logic [PIXEL_W-1:0] TEST_COLOR  = DEFAULT_TEST_COLOR
) (
  input  logic                          clk_pixel_in,
  input  logic                          rst_n_in,
  input  logic                          new_frame_in,
  input  logic                          active_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic [1:0]                    bg_mode_in,
  input  logic [NUM_LAYERS-1:0]         layer_enable_in,
  input  logic [NUM_LAYERS-1:0]         layer_blink_in,
  input  logic [PIXEL_W-1:0]            key_color_in,
  input  logic [PIXEL_W-1:0]            mask_color_in,
  input  logic                          test_force_in,
  input  logic [PIXEL_W-1:0]            camera_pixel_in,
  input  logic [CHAN_W-1:0]             camera_y_in,
  input  logic [CHAN_W-1:0]             selected_channel_in,
  input  logic                          thresholded_in,
  input  logic [NUM_LAYERS*PIXEL_W-1:0] layer_pixels_in,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic                          active_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic [$clog2(NUM_LAYERS):0]   top_layer_out
);

  localparam int TOP_W = $clog2(NUM_LAYERS) + 1;

  // Shadow configuration and frame counter
  bg_mode_e                r_bg_mode;
  logic [NUM_LAYERS-1:0]   r_layer_enable;
  logic [NUM_LAYERS-1:0]   r_layer_blink;
  logic [PIXEL_W-1:0]      r_key_color;
  logic [PIXEL_W-1:0]      r_mask_color;
  logic [FRAME_CNT_W-1:0]  r_frame_cnt;

  // Stage 1
  logic [PIXEL_W-1:0]      r_s1_bg;
  logic [PIXEL_W-1:0]      r_s1_layer [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]   r_s1_vis;
  logic                    r_s1_active;
  logic                    r_s1_hsync;
  logic                    r_s1_vsync;
  logic                    r_s1_force;

  // Stage 2 (outputs)
  logic [PIXEL_W-1:0]      r_pixel_out;
  logic [TOP_W-1:0]        r_top_layer;
  logic                    r_active_out;
  logic                    r_hsync_out;
  logic                    r_vsync_out;

  logic                    w_blink_phase;
  logic [PIXEL_W-1:0]      w_bg_pixel;
  logic [NUM_LAYERS-1:0]   w_vis;
  logic [TOP_W-1:0]        w_win_idx;
  logic                    w_win_valid;
  logic [PIXEL_W-1:0]      w_win_pixel;
  logic [PIXEL_W-1:0]      w_next_pixel;
  logic [TOP_W-1:0]        w_next_top;

  assign w_blink_phase = r_frame_cnt[BLINK_BIT];

  // Shadow config load and frame count at frame start
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      r_bg_mode      <= BG_CAMERA;
      r_layer_enable <= '0;
      r_layer_blink  <= '0;
      r_key_color    <= '0;
      r_mask_color   <= '0;
      r_frame_cnt    <= '0;
    end else if (new_frame_in) begin
      r_bg_mode      <= bg_mode_e'(bg_mode_in);
      r_layer_enable <= layer_enable_in;
      r_layer_blink  <= layer_blink_in;
      r_key_color    <= key_color_in;
      r_mask_color   <= mask_color_in;
      r_frame_cnt    <= r_frame_cnt + FRAME_CNT_W'(1);
    end
  end

  // Background source selection from the current shadow mode
  always_comb begin
    w_bg_pixel = '0;
    case (r_bg_mode)
      BG_CAMERA:  w_bg_pixel = camera_pixel_in;
      BG_CHANNEL: w_bg_pixel = {3{selected_channel_in}};
      BG_THRESH:  w_bg_pixel = thresholded_in ? {PIXEL_W{1'b1}} : {PIXEL_W{1'b0}};
      BG_YMASK:   w_bg_pixel = thresholded_in ? r_mask_color : {3{camera_y_in}};
      default:    w_bg_pixel = camera_pixel_in;
    endcase
  end

  // Per-layer visibility: enabled, not blanked by blink, not the key colour
  always_comb begin
    w_vis = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_vis[k] = r_layer_enable[k]
               && !(r_layer_blink[k] && w_blink_phase)
               && (layer_pixels_in[k*PIXEL_W +: PIXEL_W] != r_key_color);
    end
  end

  // Stage 1 register: background, layer pixels, visibility, timing
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      r_s1_bg     <= '0;
      r_s1_vis    <= '0;
      r_s1_active <= 1'b0;
      r_s1_hsync  <= 1'b0;
      r_s1_vsync  <= 1'b0;
      r_s1_force  <= 1'b0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_s1_layer[k] <= '0;
      end
    end else begin
      r_s1_bg     <= w_bg_pixel;
      r_s1_vis    <= w_vis;
      r_s1_active <= active_in;
      r_s1_hsync  <= hsync_in;
      r_s1_vsync  <= vsync_in;
      r_s1_force  <= test_force_in;
      for (int k = 0; k < NUM_LAYERS; k++) begin
        r_s1_layer[k] <= layer_pixels_in[k*PIXEL_W +: PIXEL_W];
      end
    end
  end

  layer_priority_select #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_priority (
    .vis_in    (r_s1_vis),
    .idx_out   (w_win_idx),
    .valid_out (w_win_valid)
  );

  // Fetch the winning layer's pixel
  always_comb begin
    w_win_pixel = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      if (w_win_idx == TOP_W'(k)) begin
        w_win_pixel = r_s1_layer[k];
      end else begin
        // not the winner
      end
    end
  end

  // Final pixel: blanking beats the test override, which beats layers/background
  always_comb begin
    w_next_pixel = r_s1_bg;
    w_next_top   = w_win_idx;
    if (r_s1_force) begin
      w_next_top = TOP_W'(NUM_LAYERS);
    end else begin
      w_next_top = w_win_idx;
    end
    if (!r_s1_active) begin
      w_next_pixel = '0;
    end else if (r_s1_force) begin
      w_next_pixel = TEST_COLOR;
    end else if (w_win_valid) begin
      w_next_pixel = w_win_pixel;
    end else begin
      w_next_pixel = r_s1_bg;
    end
  end

  // Stage 2 register: composited pixel, winner index, timing
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_n_in) begin
      r_pixel_out  <= '0;
      r_top_layer  <= TOP_W'(NUM_LAYERS);
      r_active_out <= 1'b0;
      r_hsync_out  <= 1'b0;
      r_vsync_out  <= 1'b0;
    end else begin
      r_pixel_out  <= w_next_pixel;
      r_top_layer  <= w_next_top;
      r_active_out <= r_s1_active;
      r_hsync_out  <= r_s1_hsync;
      r_vsync_out  <= r_s1_vsync;
    end
  end

  assign pixel_out     = r_pixel_out;
  assign top_layer_out = r_top_layer;
  assign active_out    = r_active_out;
  assign hsync_out     = r_hsync_out;
  assign vsync_out     = r_vsync_out;

endmodule

// File: tb/tb_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_layer_compositor
// Self-checking bench for layer_compositor: directed table, multi-cycle
// sequences (shadowing, blink over a full counter wrap, reset) and random
// traffic against a behavioural model with a 2-deep expected-output queue.
// ---------------------------------------------------------------------------
module tb_layer_compositor;

  logic        clk = 1'b0;
  logic        rst_n_in;
  logic        new_frame_in;
  logic        active_in, hsync_in, vsync_in;
  logic [1:0]  bg_mode_in;
  logic [3:0]  layer_enable_in, layer_blink_in;
  logic [23:0] key_color_in, mask_color_in;
  logic        test_force_in;
  logic [23:0] camera_pixel_in;
  logic [7:0]  camera_y_in, selected_channel_in;
  logic        thresholded_in;
  logic [95:0] layer_pixels_in;
  logic [23:0] pixel_out;
  logic        active_out, hsync_out, vsync_out;
  logic [2:0]  top_layer_out;

  always #5 clk = ~clk;

  layer_compositor dut (
    .clk_pixel_in        (clk),
    .rst_n_in            (rst_n_in),
    .new_frame_in        (new_frame_in),
    .active_in           (active_in),
    .hsync_in            (hsync_in),
    .vsync_in            (vsync_in),
    .bg_mode_in          (bg_mode_in),
    .layer_enable_in     (layer_enable_in),
    .layer_blink_in      (layer_blink_in),
    .key_color_in        (key_color_in),
    .mask_color_in       (mask_color_in),
    .test_force_in       (test_force_in),
    .camera_pixel_in     (camera_pixel_in),
    .camera_y_in         (camera_y_in),
    .selected_channel_in (selected_channel_in),
    .thresholded_in      (thresholded_in),
    .layer_pixels_in     (layer_pixels_in),
    .pixel_out           (pixel_out),
    .active_out          (active_out),
    .hsync_out           (hsync_out),
    .vsync_out           (vsync_out),
    .top_layer_out       (top_layer_out)
  );

  typedef struct {
    logic [23:0] pix;
    logic [2:0]  top;
    logic        act, hs, vs;
  } exp_t;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  en;
    logic [23:0] key, mask;
    logic        force_on, act, thr;
    logic [23:0] cam;
    logic [7:0]  y, sel;
    logic [23:0] l0, l1, l2, l3;
    logic [23:0] exp_pix;
    logic [2:0]  exp_top;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: shadowed configuration and frame number
  int          m_mode;
  logic [3:0]  m_en, m_blink;
  logic [23:0] m_key, m_mask;
  int          m_cnt;
  exp_t        pipe[$];
  exp_t        reset_e;

  function automatic exp_t model_pixel();
    exp_t        e;
    logic [23:0] bg;
    int          win;
    bit          blank;
    blank = ((m_cnt / 16) % 2) == 1;
    if (m_mode == 0)      bg = camera_pixel_in;
    else if (m_mode == 1) bg = {selected_channel_in, selected_channel_in, selected_channel_in};
    else if (m_mode == 2) bg = thresholded_in ? 24'hFFFFFF : 24'h000000;
    else                  bg = thresholded_in ? m_mask : {camera_y_in, camera_y_in, camera_y_in};
    win = 4;
    for (int k = 3; k >= 0; k--) begin
      if (win == 4 && m_en[k] && !(m_blink[k] && blank) && layer_pixels_in[k*24 +: 24] != m_key)
        win = k;
    end
    e.top = test_force_in ? 3'd4 : 3'(win);
    if (!active_in)         e.pix = 24'h000000;
    else if (test_force_in) e.pix = 24'hFF7700;
    else if (win < 4)       e.pix = layer_pixels_in[win*24 +: 24];
    else                    e.pix = bg;
    e.act = active_in;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    return e;
  endfunction

  task automatic check_exp(input string name, input exp_t e);
    n_checks++;
    if (pixel_out !== e.pix || top_layer_out !== e.top || active_out !== e.act ||
        hsync_out !== e.hs || vsync_out !== e.vs) begin
      n_fail++;
      $display("FAIL %s: got pix=%h top=%0d a/h/v=%b%b%b, required pix=%h top=%0d a/h/v=%b%b%b",
               name, pixel_out, top_layer_out, active_out, hsync_out, vsync_out,
               e.pix, e.top, e.act, e.hs, e.vs);
    end
  endtask

  task automatic check_pix(input string name, input logic [23:0] pix, input logic [2:0] top);
    n_checks++;
    if (pixel_out !== pix || top_layer_out !== top) begin
      n_fail++;
      $display("FAIL %s: got pix=%h top=%0d, required pix=%h top=%0d",
               name, pixel_out, top_layer_out, pix, top);
    end
  endtask

  // one clock: predict the sampled pixel, advance the model, compare outputs
  task automatic step(input string name);
    exp_t e;
    if (rst_n_in) pipe.push_back(model_pixel());
    @(posedge clk);
    if (!rst_n_in) begin
      m_mode = 0; m_en = '0; m_blink = '0; m_key = '0; m_mask = '0; m_cnt = 0;
      pipe.delete();
      pipe.push_back(reset_e);
      e = reset_e;
    end else begin
      if (new_frame_in) begin
        m_mode = int'(bg_mode_in); m_en = layer_enable_in; m_blink = layer_blink_in;
        m_key = key_color_in; m_mask = mask_color_in; m_cnt = (m_cnt + 1) % 64;
      end
      e = pipe.pop_front();
    end
    #1;
    check_exp(name, e);
  endtask

  task automatic set_layers(input logic [23:0] l0, l1, l2, l3);
    layer_pixels_in = {l3, l2, l1, l0};
  endtask

  task automatic frame_pulse();
    new_frame_in = 1'b1;
    step("frame_pulse");
    new_frame_in = 1'b0;
  endtask

  vec_t tbl[11];

  initial begin
    reset_e = '{pix: 24'h0, top: 3'd4, act: 1'b0, hs: 1'b0, vs: 1'b0};
    tbl[0]  = '{2'd0, 4'b0000, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 24'h123456, 8'h00, 8'h00,
                24'h0, 24'h0, 24'h0, 24'h0, 24'h123456, 3'd4};
    tbl[1]  = '{2'd0, 4'b1010, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 24'h111111, 8'h00, 8'h00,
                24'h0, 24'hAA0000, 24'h0, 24'h00BB00, 24'h00BB00, 3'd3};
    tbl[2]  = '{2'd0, 4'b1010, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 24'h111111, 8'h00, 8'h00,
                24'h0, 24'hAA0000, 24'h0, 24'h000000, 24'hAA0000, 3'd1};
    tbl[3]  = '{2'd3, 4'b0000, 24'h0, 24'hFF77AA, 1'b0, 1'b1, 1'b1, 24'h111111, 8'h40, 8'h00,
                24'h0, 24'h0, 24'h0, 24'h0, 24'hFF77AA, 3'd4};
    tbl[4]  = '{2'd3, 4'b0000, 24'h0, 24'hFF77AA, 1'b0, 1'b1, 1'b0, 24'h111111, 8'h40, 8'h00,
                24'h0, 24'h0, 24'h0, 24'h0, 24'h404040, 3'd4};
    tbl[5]  = '{2'd1, 4'b0000, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 24'h111111, 8'h00, 8'h5A,
                24'h0, 24'h0, 24'h0, 24'h0, 24'h5A5A5A, 3'd4};
    tbl[6]  = '{2'd2, 4'b0000, 24'h0, 24'h0, 1'b0, 1'b1, 1'b1, 24'h111111, 8'h00, 8'h00,
                24'h0, 24'h0, 24'h0, 24'h0, 24'hFFFFFF, 3'd4};
    tbl[7]  = '{2'd2, 4'b0000, 24'h0, 24'h0, 1'b0, 1'b1, 1'b0, 24'h111111, 8'h00, 8'h00,
                24'h0, 24'h0, 24'h0, 24'h0, 24'h000000, 3'd4};
    tbl[8]  = '{2'd0, 4'b1010, 24'h00BB00, 24'h0, 1'b0, 1'b1, 1'b0, 24'h111111, 8'h00, 8'h00,
                24'h0, 24'hAA0000, 24'h0, 24'h00BB00, 24'hAA0000, 3'd1};
    tbl[9]  = '{2'd0, 4'b1111, 24'h0, 24'h0, 1'b1, 1'b1, 1'b0, 24'h111111, 8'h00, 8'h00,
                24'h010101, 24'h020202, 24'h030303, 24'h040404, 24'hFF7700, 3'd4};
    tbl[10] = '{2'd0, 4'b0000, 24'h0, 24'h0, 1'b0, 1'b0, 1'b0, 24'h123456, 8'h00, 8'h00,
                24'h0, 24'h0, 24'h0, 24'h0, 24'h000000, 3'd4};

    rst_n_in = 1'b0; new_frame_in = 1'b0; active_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    bg_mode_in = 2'd0; layer_enable_in = 4'd0; layer_blink_in = 4'd0;
    key_color_in = 24'h0; mask_color_in = 24'h0; test_force_in = 1'b0;
    camera_pixel_in = 24'h0; camera_y_in = 8'h0; selected_channel_in = 8'h0;
    thresholded_in = 1'b0; layer_pixels_in = '0;

    // reset state
    for (int i = 0; i < 3; i++) step("reset");
    rst_n_in = 1'b1;

    // directed table: load config at a frame boundary, then one pixel
    for (int i = 0; i < 11; i++) begin
      bg_mode_in = tbl[i].mode; layer_enable_in = tbl[i].en; layer_blink_in = 4'd0;
      key_color_in = tbl[i].key; mask_color_in = tbl[i].mask;
      frame_pulse();
      test_force_in = tbl[i].force_on; active_in = tbl[i].act; thresholded_in = tbl[i].thr;
      camera_pixel_in = tbl[i].cam; camera_y_in = tbl[i].y; selected_channel_in = tbl[i].sel;
      set_layers(tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3);
      step("table_in");
      step("table_hold");
      check_pix($sformatf("table[%0d]", i), tbl[i].exp_pix, tbl[i].exp_top);
    end
    test_force_in = 1'b0; active_in = 1'b1;

    // shadowing: mid-frame mode change ignored; the pulse-cycle pixel uses old config
    bg_mode_in = 2'd0; layer_enable_in = 4'd0; mask_color_in = 24'hFF77AA;
    frame_pulse();
    bg_mode_in = 2'd3; thresholded_in = 1'b1; camera_pixel_in = 24'h111111;
    step("shadow_in"); step("shadow_hold");
    check_pix("shadow_ignored", 24'h111111, 3'd4);
    camera_pixel_in = 24'h222222; new_frame_in = 1'b1;
    step("shadow_pulse_in");
    new_frame_in = 1'b0; camera_pixel_in = 24'h333333;
    step("shadow_pulse_hold");
    check_pix("shadow_old_on_pulse", 24'h222222, 3'd4);
    step("shadow_new");
    check_pix("shadow_mask_hit", 24'hFF77AA, 3'd4);
    thresholded_in = 1'b0; camera_y_in = 8'h40;
    step("shadow_y_in"); step("shadow_y_hold");
    check_pix("shadow_y_grey", 24'h404040, 3'd4);

    // reset mid-line with visible layers, then shadows must be cleared
    layer_enable_in = 4'b1010; key_color_in = 24'h0; bg_mode_in = 2'd0;
    frame_pulse();
    set_layers(24'h0, 24'hAA0000, 24'h0, 24'h00BB00); hsync_in = 1'b1;
    step("pre_reset");
    rst_n_in = 1'b0;
    step("mid_reset");
    check_pix("reset_now", 24'h0, 3'd4);
    rst_n_in = 1'b1; camera_pixel_in = 24'h13579B;
    step("release_0");
    check_pix("reset_hold", 24'h0, 3'd4);
    step("release_1");
    check_pix("reset_layers_off", 24'h13579B, 3'd4);
    hsync_in = 1'b0;

    // blink: layer 0 shown in frames 0-15, hidden 16-31, shown again after wrap
    rst_n_in = 1'b0; step("blink_reset"); rst_n_in = 1'b1;
    layer_enable_in = 4'b0001; layer_blink_in = 4'b0001; key_color_in = 24'h0;
    bg_mode_in = 2'd0; camera_pixel_in = 24'h0F0F0F;
    set_layers(24'hABCDEF, 24'h0, 24'h0, 24'h0);
    frame_pulse();
    for (int f = 1; f <= 70; f++) begin
      step("blink_in"); step("blink_hold");
      if (((f % 64) / 16) % 2 == 1)
        check_pix($sformatf("blink_frame%0d", f), 24'h0F0F0F, 3'd4);
      else
        check_pix($sformatf("blink_frame%0d", f), 24'hABCDEF, 3'd0);
      frame_pulse();
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [23:0] keyc;
      keyc = ($urandom_range(0, 1) == 0) ? 24'h0 : 24'($urandom);
      rst_n_in = ($urandom_range(0, 60) != 0);
      new_frame_in = ($urandom_range(0, 7) == 0);
      active_in = ($urandom_range(0, 5) != 0);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      bg_mode_in = 2'($urandom); layer_enable_in = 4'($urandom); layer_blink_in = 4'($urandom);
      key_color_in = keyc; mask_color_in = 24'($urandom);
      test_force_in = ($urandom_range(0, 7) == 0);
      camera_pixel_in = 24'($urandom); camera_y_in = 8'($urandom);
      selected_channel_in = 8'($urandom); thresholded_in = 1'($urandom);
      for (int k = 0; k < 4; k++) begin
        layer_pixels_in[k*24 +: 24] = ($urandom_range(0, 3) == 0) ? m_key : 24'($urandom);
      end
      step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
